// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C initiator.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, MNACK, STOP
  } state_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

  localparam logic ACK     = 1'b0;
  localparam logic NACK    = 1'b1;
  localparam logic RW_READ = 1'b1;

  // Quarters in which the master holds SCL low
  function automatic logic scl_low_quarter(input quarter_t q);
    return (q == Q0) || (q == Q1);
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period timebase: one tick every CLK_DIV cycles plus the current quarter index.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     run,
  input  logic     hold,
  output logic     tick,
  output quarter_t quarter
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_reg;
  quarter_t      quarter_reg;

  assign tick    = run && !hold && (cnt_reg == CW'(CLK_DIV - 1));
  assign quarter = quarter_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      quarter_reg <= Q0;
    end else if (!run) begin
      cnt_reg     <= '0;
      quarter_reg <= Q0;
    end else if (!hold) begin
      if (cnt_reg == CW'(CLK_DIV - 1)) begin
        cnt_reg     <= '0;
        quarter_reg <= quarter_t'(quarter_reg + 2'd1);
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, addr+R/W, one data byte, STOP.
// Optional slave clock stretching is enabled with `define I2C_CLK_STRETCH_EN.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr_rw,
  input  logic [7:0] wdata,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  state_t     state_reg, state_next;
  quarter_t   quarter;
  logic       tick, hold, bit_end, sample_pt, accept;
  logic [15:0] tx_reg;
  logic [7:0] rx_reg, rdata_reg;
  logic [2:0] bit_cnt_reg;
  logic       rw_reg, ack_err_reg, busy_reg, done_reg;

  assign accept    = (state_reg == IDLE) && start;
  assign bit_end   = tick && (quarter == Q3);
  assign sample_pt = tick && (quarter == Q2);

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low while we release it freezes the timebase
  assign hold = ((quarter == Q2) || (quarter == Q3)) && !scl_oe && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold = 1'b0;
`endif

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .run     (state_reg != IDLE),
    .hold    (hold),
    .tick    (tick),
    .quarter (quarter)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = START;
      START: if (bit_end) state_next = ADDR;
      ADDR:  if (bit_end && bit_cnt_reg == 3'd7) state_next = AACK;
      AACK: begin
        if (bit_end) begin
          if (ack_err_reg)            state_next = STOP;
          else if (rw_reg == RW_READ) state_next = RDATA;
          else                        state_next = WDATA;
        end
      end
      WDATA: if (bit_end && bit_cnt_reg == 3'd7) state_next = WACK;
      WACK:  if (bit_end) state_next = STOP;
      RDATA: if (bit_end && bit_cnt_reg == 3'd7) state_next = MNACK;
      MNACK: if (bit_end) state_next = STOP;
      STOP:  if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus drive decoded from state and quarter; SDA only moves at q0 entry
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_reg)
      START: sda_oe = (quarter == Q2) || (quarter == Q3);
      ADDR, WDATA: begin
        scl_oe = scl_low_quarter(quarter);
        sda_oe = ~tx_reg[15];
      end
      AACK, WACK, RDATA, MNACK: scl_oe = scl_low_quarter(quarter);
      STOP: begin
        scl_oe = scl_low_quarter(quarter);
        sda_oe = (quarter != Q3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_reg      <= '0;
      rx_reg      <= '0;
      rdata_reg   <= '0;
      bit_cnt_reg <= '0;
      rw_reg      <= 1'b0;
      ack_err_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        tx_reg      <= {addr_rw, wdata};
        rw_reg      <= addr_rw[0];
        ack_err_reg <= 1'b0;
        bit_cnt_reg <= '0;
        busy_reg    <= 1'b1;
      end
      if (sample_pt) begin
        if (state_reg == RDATA) rx_reg <= {rx_reg[6:0], sda_in};
        if ((state_reg == AACK || state_reg == WACK) && sda_in == NACK) ack_err_reg <= 1'b1;
      end
      if (bit_end) begin
        if (state_reg == ADDR || state_reg == WDATA || state_reg == RDATA)
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (state_reg == ADDR || state_reg == WDATA)
          tx_reg <= {tx_reg[14:0], 1'b0};
        if (state_reg == MNACK) rdata_reg <= rx_reg;
        if (state_reg == STOP) begin
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
        end
      end
    end
  end

  assign rdata   = rdata_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign ack_err = ack_err_reg;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: open-drain bus, behavioural slave at 7'b1111001, vector table plus corner sequences.
module tb_i2c_master;

  localparam int CLK_DIV = 4;
  localparam int LAT_FULL = 80 * CLK_DIV;
  localparam int LAT_NACK = 44 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] addr_rw = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       scl_in, sda_in;
  logic       scl_oe, sda_oe, busy, done, ack_err;
  logic [7:0] rdata;

  int total = 0;
  int bad = 0;

  // Slave model state
  logic       slv_sda_drv = 1'b0;
  logic       slv_scl_hold = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       bits [0:31];
  int         rc = 0;
  int         stop_cnt = 0;
  int         hc = 0;
  logic       sel = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] slv_data = 8'h00;
  logic       slv_nack_data = 1'b0;
  logic       stretch_en = 1'b0;

  always #5 clk = ~clk;

  assign scl_in = ~(scl_oe | slv_scl_hold);
  assign sda_in = ~(sda_oe | slv_sda_drv);

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr_rw (addr_rw),
    .wdata   (wdata),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err)
  );

  function automatic logic [7:0] byte_at(input int base);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = bits[base+i];
    return r;
  endfunction

  // Bus-level slave: records bits on SCL rise, drives SDA after SCL fall
  always @(negedge clk) begin
    prev_scl <= scl_in;
    prev_sda <= sda_in;
    if (hc > 0) begin
      hc <= hc - 1;
      if (hc == 1) slv_scl_hold <= 1'b0;
    end
    if (prev_scl && scl_in && prev_sda && !sda_in) begin
      rc <= 0;
      sel <= 1'b0;
      slv_sda_drv <= 1'b0;
    end else if (prev_scl && scl_in && !prev_sda && sda_in) begin
      stop_cnt <= stop_cnt + 1;
    end else if (!prev_scl && scl_in) begin
      if (rc < 32) bits[rc] <= sda_in;
      rc <= rc + 1;
    end else if (prev_scl && !scl_in) begin
      if (rc == 8 && (byte_at(0) & 8'hFE) == 8'hF2) begin
        sel <= 1'b1;
        rd <= bits[7];
        slv_sda_drv <= 1'b1;
        if (stretch_en) begin
          slv_scl_hold <= 1'b1;
          hc <= 2 * CLK_DIV + 10;
        end
      end else if (rc >= 9 && rc <= 16) begin
        slv_sda_drv <= sel && rd && !slv_data[16-rc];
      end else if (rc == 17) begin
        slv_sda_drv <= sel && !rd && !slv_nack_data;
      end else begin
        slv_sda_drv <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge where done (+tail) was seen
  task automatic do_txn(input logic [7:0] a, input logic [7:0] d, input int pulse_at,
                        input int tail, output int lat, output int ndone,
                        output logic err_d, output logic [7:0] rd_d,
                        output int rc_d, output int stops);
    int stop0;
    stop0 = stop_cnt;
    lat = -1;
    ndone = 0;
    err_d = 1'b0;
    rd_d = 8'h00;
    rc_d = 0;
    stops = 0;
    addr_rw = a;
    wdata = d;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    for (int c = 1; c <= 1000; c++) begin
      if (c == pulse_at) begin
        start = 1'b1;
        addr_rw = 8'hA0;
        wdata = 8'h00;
      end
      @(posedge clk);
      @(negedge clk);
      if (c == pulse_at) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = c;
          err_d = ack_err;
          rd_d = rdata;
          rc_d = rc;
          stops = stop_cnt - stop0;
        end
      end
      if (lat >= 0 && c >= lat + tail) break;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] sdata;
    logic       nack_d;
    int         lat;
    logic       err;
    int         rc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat, ndone, rcv, stops;
    logic err;
    logic [7:0] rdv;

    vecs[0] = '{8'hF2, 8'h7A, 8'h00, 1'b0, LAT_FULL, 1'b0, 19};
    vecs[1] = '{8'hF3, 8'h00, 8'h5A, 1'b0, LAT_FULL, 1'b0, 19};
    vecs[2] = '{8'hA0, 8'h55, 8'h00, 1'b0, LAT_NACK, 1'b1, 10};
    vecs[3] = '{8'hF2, 8'h81, 8'h00, 1'b1, LAT_FULL, 1'b1, 19};
    vecs[4] = '{8'hF3, 8'hFF, 8'hA5, 1'b0, LAT_FULL, 1'b0, 19};
    vecs[5] = '{8'hA1, 8'h00, 8'h00, 1'b0, LAT_NACK, 1'b1, 10};

    repeat (3) @(negedge clk);
    chk("rst_scl_oe", int'(scl_oe), 0);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ack_err", int'(ack_err), 0);
    chk("rst_rdata", int'(rdata), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors run back to back: each start lands on the cycle after the previous done
    for (int i = 0; i < 6; i++) begin
      slv_data = vecs[i].sdata;
      slv_nack_data = vecs[i].nack_d;
      do_txn(vecs[i].a, vecs[i].d, -1, 0, lat, ndone, err, rdv, rcv, stops);
      $display("txn %0d addr_rw=%h wdata=%h lat=%0d ack_err=%0b rdata=%h clocks=%0d",
               i, vecs[i].a, vecs[i].d, lat, err, rdv, rcv);
      chk("latency", lat, vecs[i].lat);
      chk("ack_err", int'(err), int'(vecs[i].err));
      chk("scl_clocks", rcv, vecs[i].rc);
      chk("stop_seen", stops, 1);
      chk("bus_addr_byte", int'(byte_at(0)), int'(vecs[i].a));
      if (vecs[i].rc == 19) begin
        chk("bus_addr_ack", int'(bits[8]), 0);
        if (vecs[i].a[0]) begin
          chk("bus_read_byte", int'(byte_at(9)), int'(vecs[i].sdata));
          chk("master_nack", int'(bits[17]), 1);
          chk("rdata", int'(rdv), int'(vecs[i].sdata));
        end else begin
          chk("bus_write_byte", int'(byte_at(9)), int'(vecs[i].d));
          chk("bus_data_ack", int'(bits[17]), int'(vecs[i].nack_d));
        end
      end else begin
        chk("bus_addr_nack", int'(bits[8]), 1);
      end
    end

    // start pulsed mid-transfer must be ignored
    slv_nack_data = 1'b0;
    do_txn(8'hF2, 8'h7A, 50, 400, lat, ndone, err, rdv, rcv, stops);
    $display("txn busy-start lat=%0d dones=%0d ack_err=%0b", lat, ndone, err);
    chk("busy_start_latency", lat, LAT_FULL);
    chk("busy_start_dones", ndone, 1);
    chk("busy_start_wbyte", int'(byte_at(9)), 8'h7A);
    chk("busy_start_addr", int'(byte_at(0)), 8'hF2);
    chk("busy_start_idle", int'(busy), 0);

    // Reset during ADDR bit 3
    addr_rw = 8'hF2;
    wdata = 8'h7A;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (69) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_scl_low", int'(scl_oe), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_scl_oe", int'(scl_oe), 0);
    chk("mid_rst_sda_oe", int'(sda_oe), 0);
    chk("mid_rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    do_txn(8'hF2, 8'h7A, -1, 0, lat, ndone, err, rdv, rcv, stops);
    $display("txn after-reset lat=%0d ack_err=%0b clocks=%0d", lat, err, rcv);
    chk("post_rst_latency", lat, LAT_FULL);
    chk("post_rst_ack_err", int'(err), 0);
    chk("post_rst_wbyte", int'(byte_at(9)), 8'h7A);

    // Slave stretches SCL at AACK
    stretch_en = 1'b1;
    do_txn(8'hF2, 8'h3C, -1, 0, lat, ndone, err, rdv, rcv, stops);
    stretch_en = 1'b0;
    $display("txn stretch lat=%0d ack_err=%0b", lat, err);
`ifdef I2C_CLK_STRETCH_EN
    chk("stretch_latency", lat, LAT_FULL + 10);
`else
    chk("stretch_latency", lat, LAT_FULL);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
